// File: rtl/dmem_pkg.sv
// Shared constants for the data memory with peripheral window: access size
// codes, peripheral register offsets, timer control bit positions and the
// load-extension helper.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [4:0] OFF_TH      = 5'h00;
  localparam logic [4:0] OFF_TL      = 5'h04;
  localparam logic [4:0] OFF_TCON    = 5'h08;
  localparam logic [4:0] OFF_LED     = 5'h0C;
  localparam logic [4:0] OFF_BCD7    = 5'h10;
  localparam logic [4:0] OFF_SYSTICK = 5'h14;

  localparam logic [31:0] MMIO_SIZE = 32'h20;

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_ST = 2;

  // Sign- or zero-extend a lane already shifted down to bit 0; size 11 acts as word.
  function automatic logic [31:0] load_extend(input logic [31:0] raw,
                                              input logic [1:0]  size,
                                              input logic        uns);
    logic [31:0] res;
    case (size)
      SZ_BYTE: res = uns ? {24'h0, raw[7:0]}   : {{24{raw[7]}}, raw[7:0]};
      SZ_HALF: res = uns ? {16'h0, raw[15:0]}  : {{16{raw[15]}}, raw[15:0]};
      default: res = raw;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mmio_timer.sv
// Reloadable timer with sticky interrupt status plus a free-running tick
// counter. Registers: TH (reload), TL (count), TCON (en/ie/status), SYSTICK.
module mmio_timer
  import dmem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_we,
  input  logic [4:0]  i_off,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_irq
);

  logic [31:0] r_th;
  logic [31:0] r_tl;
  logic [2:0]  r_tcon;
  logic [31:0] r_systick;
  logic        w_ovf;
  logic        w_set;

  assign w_ovf = r_tcon[TCON_EN] && (r_tl == 32'hFFFF_FFFF);
  assign w_set = w_ovf && r_tcon[TCON_IE];
  assign o_irq = r_tcon[TCON_ST];

  // Reload value register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                        r_th <= '0;
    else if (i_we && i_off == OFF_TH)  r_th <= i_wdata;
  end

  // Count register: a CPU write wins over both increment and reload
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                        r_tl <= '0;
    else if (i_we && i_off == OFF_TL)  r_tl <= i_wdata;
    else if (w_ovf)                    r_tl <= r_th;
    else if (r_tcon[TCON_EN])          r_tl <= r_tl + 32'd1;
  end

  // Control/status: an overflow setting status is never lost to a CPU write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          r_tcon <= '0;
    else if (i_we && i_off == OFF_TCON)  r_tcon <= {i_wdata[2] | w_set, i_wdata[1:0]};
    else if (w_set)                      r_tcon[TCON_ST] <= 1'b1;
  end

  // Free-running tick counter, wraps naturally
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_systick <= '0;
    else        r_systick <= r_systick + 32'd1;
  end

  // Register read mux; offsets not owned here read 0
  always_comb begin
    o_rdata = '0;
    case (i_off)
      OFF_TH:      o_rdata = r_th;
      OFF_TL:      o_rdata = r_tl;
      OFF_TCON:    o_rdata = {29'h0, r_tcon};
      OFF_SYSTICK: o_rdata = r_systick;
      default:     o_rdata = '0;
    endcase
  end

endmodule

// File: rtl/data_memory_mmio.sv
// MEM-stage data memory: word RAM with byte/half/word lanes and a 0x20-byte
// peripheral window (timer, LED, BCD7). Loads are combinational.
module data_memory_mmio
  import dmem_pkg::*;
#(
  parameter int          RAM_WORDS = 256,
  parameter logic [31:0] MMIO_BASE = 32'h4000_0000,
  parameter int          LED_WIDTH = 8,
  parameter int          BCD_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 MemRead,
  input  logic                 MemWrite,
  input  logic [1:0]           MemSize,
  input  logic                 MemUnsigned,
  input  logic [31:0]          Address,
  input  logic [31:0]          Write_data,
  output logic [31:0]          Read_data,
  output logic                 addr_err,
  output logic [LED_WIDTH-1:0] leds,
  output logic [BCD_WIDTH-1:0] bcd7,
  output logic                 irq
);

  localparam int          IDX_W     = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  logic [31:0]          r_mem [RAM_WORDS];
  logic [LED_WIDTH-1:0] r_led;
  logic [BCD_WIDTH-1:0] r_bcd;

  logic             w_ram_hit;
  logic             w_mmio_hit;
  logic             w_misalign;
  logic             w_bad;
  logic             w_ram_we;
  logic             w_mmio_we;
  logic [IDX_W-1:0] w_idx;
  logic [4:0]       w_off;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata;
  logic [31:0]      w_word;
  logic [31:0]      w_tmr_rdata;

  assign w_ram_hit  = Address < RAM_BYTES;
  assign w_mmio_hit = (Address >= MMIO_BASE) && (Address < MMIO_BASE + MMIO_SIZE);
  assign w_misalign = (w_mmio_hit || MemSize[1]) ? (Address[1:0] != 2'b00)
                                                 : ((MemSize == SZ_HALF) && Address[0]);
  assign w_bad      = w_misalign || !(w_ram_hit || w_mmio_hit);
  assign addr_err   = (MemRead || MemWrite) && w_bad;
  assign w_ram_we   = MemWrite && w_ram_hit && !w_bad;
  assign w_mmio_we  = MemWrite && w_mmio_hit && !w_bad;
  assign w_idx      = Address[IDX_W+1:2];
  assign w_off      = 5'(Address - MMIO_BASE);
  assign w_word     = r_mem[w_idx];
  assign leds       = r_led;
  assign bcd7       = r_bcd;

  // Lane enables and replicated store data for the access size
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = Write_data;
    case (MemSize)
      SZ_BYTE: begin
        w_be    = 4'b0001 << Address[1:0];
        w_wdata = {4{Write_data[7:0]}};
      end
      SZ_HALF: begin
        w_be    = Address[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{Write_data[15:0]}};
      end
      default: ;
    endcase
  end

  // RAM storage: cleared on reset, lane-masked stores
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RAM_WORDS; i++) r_mem[i] <= '0;
    end else if (w_ram_we) begin
      for (int b = 0; b < 4; b++)
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
    end
  end

  // LED and BCD7 output registers; BCD7 resets to all segments off
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_led <= '0;
      r_bcd <= '1;
    end else if (w_mmio_we) begin
      if (w_off == OFF_LED)  r_led <= Write_data[LED_WIDTH-1:0];
      if (w_off == OFF_BCD7) r_bcd <= Write_data[BCD_WIDTH-1:0];
    end
  end

  mmio_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_mmio_we),
    .i_off   (w_off),
    .i_wdata (Write_data),
    .o_rdata (w_tmr_rdata),
    .o_irq   (irq)
  );

  // Load path: lane extract and extend for RAM, register mux for the window
  always_comb begin
    Read_data = '0;
    if (MemRead && !w_bad) begin
      if (w_ram_hit) begin
        Read_data = load_extend(w_word >> {Address[1:0], 3'b000}, MemSize, MemUnsigned);
      end else begin
        case (w_off)
          OFF_LED:  Read_data = 32'(r_led);
          OFF_BCD7: Read_data = 32'(r_bcd);
          default:  Read_data = w_tmr_rdata;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_data_memory_mmio.sv
module tb_data_memory_mmio;

  localparam int          RAM_WORDS = 256;
  localparam int          RAM_BYTES = RAM_WORDS * 4;
  localparam logic [31:0] MB        = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [1:0]  MemSize = 2'b10;
  logic        MemUnsigned = 1'b0;
  logic [31:0] Address = '0;
  logic [31:0] Write_data = '0;
  logic [31:0] Read_data;
  logic        addr_err;
  logic [7:0]  leds;
  logic [11:0] bcd7;
  logic        irq;

  int total = 0;
  int bad   = 0;

  logic [7:0] ref_b [RAM_BYTES];

  data_memory_mmio #(.RAM_WORDS(RAM_WORDS), .MMIO_BASE(MB), .LED_WIDTH(8), .BCD_WIDTH(12)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemSize(MemSize), .MemUnsigned(MemUnsigned), .Address(Address),
    .Write_data(Write_data), .Read_data(Read_data), .addr_err(addr_err),
    .leds(leds), .bcd7(bcd7), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit model_mis(input int a, input logic [1:0] sz);
    return (a % nbytes(sz)) != 0;
  endfunction

  function automatic logic [31:0] model_load(input int a, input logic [1:0] sz, input logic u);
    longint v = 0;
    int n = nbytes(sz);
    for (int k = 0; k < n; k++) v += longint'(ref_b[a + k]) << (8 * k);
    if (!u && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
    return 32'(v);
  endfunction

  task automatic model_store(input int a, input logic [31:0] d, input logic [1:0] sz);
    for (int k = 0; k < nbytes(sz); k++) ref_b[a + k] = 8'(d >> (8 * k));
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    Address = a; Write_data = d; MemSize = sz; MemRead = 1'b0; MemWrite = 1'b1;
    @(posedge clk); #1;
    MemWrite = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [1:0] sz, input logic u,
                    output logic [31:0] d, output logic e);
    Address = a; MemSize = sz; MemUnsigned = u; MemRead = 1'b1; MemWrite = 1'b0;
    #1;
    d = Read_data; e = addr_err;
    MemRead = 1'b0;
  endtask

  initial begin
    logic [31:0] d, exp;
    logic        e;
    for (int i = 0; i < RAM_BYTES; i++) ref_b[i] = 8'h00;

    // reset and initial state
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    #1;
    check_eq("idle_err", {31'h0, addr_err}, 32'h0);
    check_eq("rst_irq", {31'h0, irq}, 32'h0);
    check_eq("rst_leds", {24'h0, leds}, 32'h0);
    check_eq("rst_bcd7", {20'h0, bcd7}, 32'hFFF);
    rd(MB + 32'h10, 2'b10, 1'b0, d, e); check_eq("rst_bcd_rd", d, 32'h0000_0FFF);
    rd(32'h0, 2'b10, 1'b0, d, e);       check_eq("rst_ram0", d, 32'h0);
    @(posedge clk); #1;

    // sub-word lanes
    wr(32'h8, 32'h1122_3344, 2'b10); model_store(8, 32'h1122_3344, 2'b10);
    wr(32'h9, 32'h0000_00AB, 2'b00); model_store(9, 32'hAB, 2'b00);
    rd(32'h8, 2'b10, 1'b0, d, e); check_eq("sb_word", d, 32'h1122_AB44);
    rd(32'h9, 2'b00, 1'b0, d, e); check_eq("lb", d, 32'hFFFF_FFAB);
    rd(32'h9, 2'b00, 1'b1, d, e); check_eq("lbu", d, 32'h0000_00AB);
    rd(32'hA, 2'b01, 1'b0, d, e); check_eq("lh", d, 32'h0000_1122);
    rd(32'h8, 2'b11, 1'b0, d, e); check_eq("size11_word", d, 32'h1122_AB44);

    // errors and boundaries
    Address = 32'h3; Write_data = 32'hBEEF; MemSize = 2'b01; MemWrite = 1'b1; #1;
    check_eq("sh_mis_err", {31'h0, addr_err}, 32'h1);
    @(posedge clk); #1; MemWrite = 1'b0;
    rd(32'h0, 2'b10, 1'b0, d, e); check_eq("sh_mis_nowr", d, 32'h0);
    rd(32'h0010_0000, 2'b10, 1'b0, d, e);
    check_eq("unmap_err", {31'h0, e}, 32'h1); check_eq("unmap_data", d, 32'h0);
    rd(32'(RAM_BYTES - 4), 2'b10, 1'b0, d, e); check_eq("ram_top_err", {31'h0, e}, 32'h0);
    rd(32'(RAM_BYTES), 2'b10, 1'b0, d, e);     check_eq("ram_end_err", {31'h0, e}, 32'h1);
    rd(MB + 32'h12, 2'b01, 1'b0, d, e);        check_eq("mmio_mis_err", {31'h0, e}, 32'h1);
    rd(MB + 32'h20, 2'b10, 1'b0, d, e);        check_eq("mmio_end_err", {31'h0, e}, 32'h1);
    rd(MB - 32'h4, 2'b10, 1'b0, d, e);         check_eq("mmio_below_err", {31'h0, e}, 32'h1);
    rd(MB + 32'h1C, 2'b10, 1'b0, d, e);
    check_eq("rsv_err", {31'h0, e}, 32'h0); check_eq("rsv_data", d, 32'h0);
    @(posedge clk); #1;

    // LED / BCD7 with random values; size field ignored in the window
    for (int i = 0; i < 4; i++) begin
      logic [31:0] v;
      v = $urandom;
      wr(MB + 32'h0C, v, 2'(i % 3));
      check_eq("leds_out", {24'h0, leds}, {24'h0, v[7:0]});
      rd(MB + 32'h0C, 2'b00, 1'b0, d, e); check_eq("led_rd", d, {24'h0, v[7:0]});
      v = $urandom;
      wr(MB + 32'h10, v, 2'b10);
      check_eq("bcd_out", {20'h0, bcd7}, {20'h0, v[11:0]});
      rd(MB + 32'h10, 2'b10, 1'b0, d, e); check_eq("bcd_rd", d, {20'h0, v[11:0]});
    end

    // random RAM traffic against the byte-array model
    for (int it = 0; it < 300; it++) begin
      int op, a;
      logic [1:0] sz;
      logic u;
      bit mis;
      op = int'($urandom_range(0, 3));
      sz = 2'($urandom_range(0, 3));
      u  = 1'($urandom_range(0, 1));
      a  = int'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) a = a - (a % nbytes(sz));
      mis = model_mis(a, sz);
      case (op)
        0, 1: begin
          d = $urandom;
          Address = 32'(a); Write_data = d; MemSize = sz; MemRead = 1'b0; MemWrite = 1'b1; #1;
          check_eq("st_err", {31'h0, addr_err}, {31'h0, mis});
          @(posedge clk); #1; MemWrite = 1'b0;
          if (!mis) model_store(a, d, sz);
        end
        2: begin
          rd(32'(a), sz, u, d, e);
          exp = mis ? 32'h0 : model_load(a, sz, u);
          check_eq("ld_err", {31'h0, e}, {31'h0, mis});
          check_eq("ld_data", d, exp);
        end
        default: begin
          a = a - (a % 4);
          exp = model_load(a, 2'b10, 1'b0);
          d = $urandom;
          Address = 32'(a); Write_data = d; MemSize = 2'b10; MemRead = 1'b1; MemWrite = 1'b1; #1;
          check_eq("rw_old", Read_data, exp);
          @(posedge clk); #1; MemRead = 1'b0; MemWrite = 1'b0;
          model_store(a, d, 2'b10);
          rd(32'(a), 2'b10, 1'b0, d, e); check_eq("rw_new", d, model_load(a, 2'b10, 1'b0));
        end
      endcase
    end

    // timer overflow and reload
    wr(MB + 32'h00, 32'hFFFF_FFF0, 2'b10);
    wr(MB + 32'h04, 32'hFFFF_FFFE, 2'b10);
    wr(MB + 32'h08, 32'h3, 2'b10);
    rd(MB + 32'h04, 2'b10, 1'b0, d, e); check_eq("tl_start", d, 32'hFFFF_FFFE);
    @(posedge clk); #1;
    rd(MB + 32'h04, 2'b10, 1'b0, d, e); check_eq("tl_max", d, 32'hFFFF_FFFF);
    check_eq("irq_pre", {31'h0, irq}, 32'h0);
    @(posedge clk); #1;
    rd(MB + 32'h04, 2'b10, 1'b0, d, e); check_eq("tl_reload", d, 32'hFFFF_FFF0);
    check_eq("irq_set", {31'h0, irq}, 32'h1);

    // status clear racing an overflow: the set must win
    wr(MB + 32'h08, 32'h0, 2'b10);
    check_eq("irq_clr", {31'h0, irq}, 32'h0);
    wr(MB + 32'h04, 32'hFFFF_FFFD, 2'b10);
    wr(MB + 32'h08, 32'h3, 2'b10);
    @(posedge clk); #1;
    rd(MB + 32'h04, 2'b10, 1'b0, d, e); check_eq("tl_fe", d, 32'hFFFF_FFFE);
    @(posedge clk); #1;
    rd(MB + 32'h04, 2'b10, 1'b0, d, e); check_eq("tl_ff", d, 32'hFFFF_FFFF);
    wr(MB + 32'h08, 32'h3, 2'b10);
    check_eq("irq_race", {31'h0, irq}, 32'h1);
    rd(MB + 32'h08, 2'b10, 1'b0, d, e); check_eq("tcon_race", d, 32'h7);
    rd(MB + 32'h04, 2'b10, 1'b0, d, e); check_eq("tl_race", d, 32'hFFFF_FFF0);
    @(posedge clk); #1;
    wr(MB + 32'h08, 32'h3, 2'b10);
    check_eq("irq_clr2", {31'h0, irq}, 32'h0);
    rd(MB + 32'h08, 2'b10, 1'b0, d, e); check_eq("tcon_clr2", d, 32'h3);

    // asynchronous reset mid-count, then SYSTICK restart
    wr(MB + 32'h08, 32'h1, 2'b10);
    wr(MB + 32'h04, 32'h123, 2'b10);
    wr(MB + 32'h08, 32'h0, 2'b10);
    rd(MB + 32'h04, 2'b10, 1'b0, d, e); check_eq("tl_pre_rst", d, 32'h124);
    wr(MB + 32'h08, 32'h3, 2'b10);
    #1; reset = 1'b0; #1;
    rd(MB + 32'h04, 2'b10, 1'b0, d, e); check_eq("rst_tl", d, 32'h0);
    rd(MB + 32'h08, 2'b10, 1'b0, d, e); check_eq("rst_tcon", d, 32'h0);
    check_eq("rst_irq2", {31'h0, irq}, 32'h0);
    check_eq("rst_bcd2", {20'h0, bcd7}, 32'hFFF);
    rd(32'h8, 2'b10, 1'b0, d, e); check_eq("rst_ram8", d, 32'h0);
    @(negedge clk); reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rd(MB + 32'h14, 2'b10, 1'b0, d, e); check_eq("systick5", d, 32'd5);
    wr(MB + 32'h14, 32'hDEAD_0000, 2'b10);
    rd(MB + 32'h14, 2'b10, 1'b0, d, e); check_eq("systick_ro", d, 32'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
